// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: select encodings and default datapath width shared by the KGP-RISC datapath blocks.
package kgp_risc_pkg;
    localparam int DATA_W = 32;
    typedef logic [1:0] sel_t;
    localparam sel_t SEL_CH0 = 2'b00;
    localparam sel_t SEL_CH1 = 2'b01;
    localparam sel_t SEL_CH2 = 2'b10;
    localparam sel_t SEL_CH3 = 2'b11;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register with valid flag; delivered-word counter when DEMUX_COUNT_EN is defined.
module demux_slot
    import kgp_risc_pkg::*;
#(
    parameter int DW = DATA_W
`ifdef DEMUX_COUNT_EN
    , parameter int CW = 16
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fill,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data
`ifdef DEMUX_COUNT_EN
    , output logic [CW-1:0] out_cnt
`endif
);
    logic          r_valid;
    logic [DW-1:0] r_data;
    // a fill wins over a drain, so drain+fill keeps the slot full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= fill | (r_valid & ~out_ready);
            if (fill) r_data <= in_data;
        end
    end
    assign out_valid = r_valid;
    assign out_data  = r_data;
`ifdef DEMUX_COUNT_EN
    logic [CW-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst) r_cnt <= '0;
        else if (r_valid & out_ready) r_cnt <= r_cnt + CW'(1);
    end
    assign out_cnt = r_cnt;
`endif
endmodule

// File: rtl/demux1to4_reg.sv
// demux1to4_reg: registered 1-to-4 demux with per-channel valid/ready holding registers.
// Optional per-channel delivered counters via DEMUX_COUNT_EN.
module demux1to4_reg
    import kgp_risc_pkg::*;
#(
    parameter int DW = DATA_W
`ifdef DEMUX_COUNT_EN
    , parameter int CW = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      select,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*DW-1:0] out_data
`ifdef DEMUX_COUNT_EN
    , output logic [4*CW-1:0] out_cnt
`endif
);
    logic [3:0] w_dec;
    logic       w_in_ready;
    logic [3:0] w_fill;
    always_comb begin
        w_dec      = {select == SEL_CH3, select == SEL_CH2, select == SEL_CH1, select == SEL_CH0};
        w_in_ready = ~out_valid[select] | out_ready[select];
        w_fill     = w_dec & {4{in_valid & w_in_ready}};
    end
    assign in_ready = w_in_ready;
    for (genvar k = 0; k < 4; k++) begin : g_slot
        demux_slot #(
            .DW(DW)
`ifdef DEMUX_COUNT_EN
            , .CW(CW)
`endif
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .fill     (w_fill[k]),
            .in_data  (in_data),
            .out_ready(out_ready[k]),
            .out_valid(out_valid[k]),
            .out_data (out_data[k*DW +: DW])
`ifdef DEMUX_COUNT_EN
            , .out_cnt(out_cnt[k*CW +: CW])
`endif
        );
    end
endmodule

// File: tb/tb_demux1to4_reg.sv
// tb_demux1to4_reg: directed and random stimulus against a per-channel word-holding model.
module tb_demux1to4_reg;
    localparam int DW = 32;
`ifdef DEMUX_COUNT_EN
    localparam int CW = 4;
`endif
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    select = '0;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready = '0;
    logic [4*DW-1:0] out_data;
`ifdef DEMUX_COUNT_EN
    logic [4*CW-1:0] out_cnt;
`endif
    int checks = 0;
    int failures = 0;
    bit          mv[4];
    logic [31:0] md[4];
    int          mc[4];

    demux1to4_reg #(
        .DW(DW)
`ifdef DEMUX_COUNT_EN
        , .CW(CW)
`endif
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .select(select), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
`ifdef DEMUX_COUNT_EN
        , .out_cnt(out_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0]   ev;
        logic [127:0] ed;
        for (int k = 0; k < 4; k++) begin
            ev[k] = mv[k];
            ed[k*32 +: 32] = md[k];
        end
        chk({tag, ".out_valid"}, 128'(out_valid), 128'(ev));
        chk({tag, ".out_data"}, 128'(out_data), ed);
`ifdef DEMUX_COUNT_EN
        for (int k = 0; k < 4; k++)
            chk({tag, ".out_cnt"}, 128'(out_cnt[k*CW +: CW]), 128'(mc[k] % (1 << CW)));
`endif
    endtask

    // one clock: drive, check the combinational ready, advance the model, check registered outputs
    task automatic cycle(input string tag, input bit r, input bit v, input logic [1:0] s,
                         input logic [31:0] d, input logic [3:0] ordy);
        bit er;
        rst = r; in_valid = v; select = s; in_data = d; out_ready = ordy;
        #3;
        er = !mv[s] || ordy[s];
        chk({tag, ".in_ready"}, 128'(in_ready), 128'(er));
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                mv[k] = 0; md[k] = '0; mc[k] = 0;
            end else begin
                bit drain = mv[k] && ordy[k];
                bit fill = v && er && (s == 2'(k));
                if (drain) mc[k]++;
                if (fill) begin
                    mv[k] = 1; md[k] = d;
                end else if (drain) mv[k] = 0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            mv[k] = 0; md[k] = '0; mc[k] = 0;
        end
        check_outputs("reset");
        cycle("idle", 0, 0, 2'b00, 32'h0, 4'b0000);
        // single word to ch2, held while stalled, then drained
        cycle("t2_fill", 0, 1, 2'b10, 32'hDEADBEEF, 4'b0000);
        for (int i = 0; i < 5; i++) cycle("t2_hold", 0, 0, 2'(i), 32'h5555_0000 + i, 4'b0000);
        cycle("t2_drain", 0, 0, 2'b00, 32'h0, 4'b0100);
        // stalled ch1 blocks ch1 input only
        cycle("t3_fill1", 0, 1, 2'b01, 32'hA1A1_A1A1, 4'b0000);
        cycle("t3_block", 0, 1, 2'b01, 32'hBADBAD00, 4'b0000);
        cycle("t3_ch3", 0, 1, 2'b11, 32'h1, 4'b0000);
        cycle("t3_drain", 0, 0, 2'b00, 32'h0, 4'b1010);
        // full throughput on ch0
        for (int i = 1; i <= 4; i++) cycle("t4_stream", 0, 1, 2'b00, 32'(i), 4'b0001);
        cycle("t4_last", 0, 0, 2'b00, 32'h0, 4'b0001);
        // reset discards held words
        cycle("t5_fill0", 0, 1, 2'b00, 32'h0C0C_0C0C, 4'b0000);
        cycle("t5_fill3", 0, 1, 2'b11, 32'h0303_0303, 4'b0000);
        cycle("t5_rst", 1, 0, 2'b00, 32'h0, 4'b0000);
        cycle("t5_new", 0, 1, 2'b11, 32'h3333_3333, 4'b0000);
        cycle("t5_drain", 0, 0, 2'b00, 32'h0, 4'b1000);
        // 17 deliveries on ch2 (wraps a 4-bit counter)
        cycle("t6_rst", 1, 0, 2'b00, 32'h0, 4'b0000);
        for (int i = 0; i < 17; i++) cycle("t6_stream", 0, 1, 2'b10, 32'h600 + i, 4'b0100);
        cycle("t6_last", 0, 0, 2'b00, 32'h0, 4'b0100);
        // random traffic
        for (int i = 0; i < 400; i++)
            cycle("rand", $urandom_range(0, 49) == 0, 1'($urandom), 2'($urandom),
                  $urandom, 4'($urandom));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
